// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter and its lane unit.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WRITE  = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

endpackage

// File: rtl/dmem_lane_unit.sv
// Combinational lane handling: load extraction and read-modify-write store merge.
module dmem_lane_unit
  import dmem_arbiter_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [31:0] lane_mask;

  always_comb begin
    shamt   = {offset, 3'b000};
    shifted = rd_word >> shamt;
    case (size)
      SIZE_BYTE: begin
        load_data = {24'd0, shifted[7:0]};
        lane_mask = 32'h0000_00FF << shamt;
      end
      SIZE_HALF: begin
        load_data = {16'd0, shifted[15:0]};
        lane_mask = 32'h0000_FFFF << shamt;
      end
      default: begin
        load_data = shifted;
        lane_mask = '1;
      end
    endcase
    merged = (rd_word & ~lane_mask) | ((wdata << shamt) & lane_mask);
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between CPU MEM stage (m0)
// and loader/debug DMA (m1), with sub-word access conversion and error checks.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned MEM_AW   = 12,
  parameter logic        RR_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [1:0]  m0_size,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [1:0]  m1_size,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic        mem_ce,
  output logic        mem_we,
  output logic        mem_rr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic [3:0]  mem_rmask,
  input  logic [31:0] mem_rdata
);

  state_t      state, state_nx;
  logic        last_grant;
  logic        id_q, we_q, err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, rdata_q, merged_q;

  logic        sel_id, sel_we, sel_err;
  logic [1:0]  sel_size;
  logic [31:0] sel_addr, sel_wdata;
  logic        rmw;
  logic [3:0]  size_mask;
  logic [31:0] load_data, merged;

  // Tie goes to the master that did not win last; a lone requester wins outright.
  always_comb begin
    sel_id    = (m0_req && m1_req) ? ~last_grant : m1_req;
    sel_we    = sel_id ? m1_we    : m0_we;
    sel_size  = sel_id ? m1_size  : m0_size;
    sel_addr  = sel_id ? m1_addr  : m0_addr;
    sel_wdata = sel_id ? m1_wdata : m0_wdata;
    sel_err   = ((sel_addr >> MEM_AW) != '0)
             || (sel_size[1] && (sel_addr[1:0] != 2'b00))
             || ((sel_size == SIZE_HALF) && sel_addr[0]);
  end

  dmem_lane_unit u_lane (
    .rd_word   (mem_rdata),
    .wdata     (wdata_q),
    .offset    (addr_q[1:0]),
    .size      (size_q),
    .load_data (load_data),
    .merged    (merged)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= RR_RESET;
      id_q       <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      size_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      merged_q   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: if (m0_req || m1_req) begin
          id_q       <= sel_id;
          we_q       <= sel_we;
          err_q      <= sel_err;
          size_q     <= sel_size;
          addr_q     <= sel_addr;
          wdata_q    <= sel_wdata;
          rdata_q    <= '0;
          last_grant <= sel_id;
        end
        ST_ACCESS: if (!err_q) begin
          if (!we_q) rdata_q <= load_data;
          if (rmw)   merged_q <= merged;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rmw = we_q && !size_q[1] && (addr_q[1:0] != 2'b00);
    case (size_q)
      SIZE_BYTE: size_mask = MASK_B;
      SIZE_HALF: size_mask = MASK_H;
      default:   size_mask = MASK_W;
    endcase

    state_nx  = state;
    mem_ce    = 1'b0;
    mem_we    = 1'b0;
    mem_rr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    mem_rmask = '0;
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    m0_err    = 1'b0;
    m1_err    = 1'b0;
    m0_rdata  = '0;
    m1_rdata  = '0;

    case (state)
      ST_IDLE: if (m0_req || m1_req) state_nx = ST_ACCESS;
      ST_ACCESS: begin
        state_nx = (!err_q && rmw) ? ST_WRITE : ST_RESP;
        if (!err_q) begin
          mem_ce    = 1'b1;
          mem_addr  = {addr_q[31:2], 2'b00};
          mem_rmask = MASK_W;
          if (!we_q || rmw) begin
            mem_rr = 1'b1;
          end else begin
            mem_we    = 1'b1;
            mem_wmask = size_mask;
            mem_wdata = wdata_q;
          end
        end
      end
      ST_WRITE: begin
        state_nx  = ST_RESP;
        mem_ce    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {addr_q[31:2], 2'b00};
        mem_wmask = MASK_W;
        mem_rmask = MASK_W;
        mem_wdata = merged_q;
      end
      ST_RESP: begin
        state_nx = ST_IDLE;
        if (id_q) begin
          m1_ack   = 1'b1;
          m1_err   = err_q;
          m1_rdata = rdata_q;
        end else begin
          m0_ack   = 1'b1;
          m0_err   = err_q;
          m0_rdata = rdata_q;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed-vector bench for dmem_arbiter with a small byte-lane memory model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [1:0]  m0_size, m1_size;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_ce, mem_we, mem_rr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask, mem_rmask;

  logic [31:0] mem [0:1023];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_AW(12), .RR_RESET(1'b1)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_rr(mem_rr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rmask(mem_rmask), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[11:2]];

  always @(posedge clk) begin
    if (mem_ce && mem_we) begin
      if (mem_wmask[0]) mem[mem_addr[11:2]][7:0]   <= mem_wdata[7:0];
      if (mem_wmask[1]) mem[mem_addr[11:2]][15:8]  <= mem_wdata[15:8];
      if (mem_wmask[2]) mem[mem_addr[11:2]][23:16] <= mem_wdata[23:16];
      if (mem_wmask[3]) mem[mem_addr[11:2]][31:24] <= mem_wdata[31:24];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one request from master m; called on a negedge while the DUT is in IDLE.
  task automatic do_req(input int m, input logic we, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int cyc, output logic [31:0] rdata, output logic err,
                        output logic ce_seen, output logic [3:0] wmask_w,
                        output logic [31:0] wdata_w);
    logic got = 1'b0;
    if (m == 0) begin
      m0_we = we; m0_size = size; m0_addr = addr; m0_wdata = wdata; m0_req = 1'b1;
    end else begin
      m1_we = we; m1_size = size; m1_addr = addr; m1_wdata = wdata; m1_req = 1'b1;
    end
    cyc = 0; rdata = '0; err = 1'b0; ce_seen = 1'b0; wmask_w = '0; wdata_w = '0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      cyc++;
      if (mem_ce) ce_seen = 1'b1;
      if (mem_we) begin
        wmask_w = mem_wmask;
        wdata_w = mem_wdata;
      end
      if ((m == 0) ? m0_ack : m1_ack) begin
        got   = 1'b1;
        rdata = (m == 0) ? m0_rdata : m1_rdata;
        err   = (m == 0) ? m0_err : m1_err;
      end
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    if (!got) check("ack_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  int          cyc;
  logic [31:0] rd, wd;
  logic        er, ce;
  logic [3:0]  wm;
  int          ack_id [4];
  int          ack_at [4];
  logic [31:0] ack_rd [4];
  int          nack;
  logic        stray;

  initial begin
    rst = 1'b1;
    m0_req = 0; m0_we = 0; m0_size = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_size = 0; m1_addr = 0; m1_wdata = 0;
    repeat (2) @(negedge clk);
    check("rst_ack", {30'd0, m1_ack, m0_ack}, 32'd0);
    check("rst_mem_ctl", {29'd0, mem_ce, mem_we, mem_rr}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_rdata", m0_rdata | m1_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Word store then word load.
    do_req(0, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF, cyc, rd, er, ce, wm, wd);
    check("wst_lat", cyc, 2);
    check("wst_wmask", {28'd0, wm}, 32'hF);
    check("wst_err", {31'd0, er}, 0);
    do_req(0, 1'b0, 2'b10, 32'h10, 32'h0, cyc, rd, er, ce, wm, wd);
    check("wld_lat", cyc, 2);
    check("wld_data", rd, 32'hDEADBEEF);

    // Read-modify-write byte and half stores.
    do_req(0, 1'b1, 2'b10, 32'h20, 32'h11223344, cyc, rd, er, ce, wm, wd);
    do_req(1, 1'b1, 2'b00, 32'h23, 32'h000000AA, cyc, rd, er, ce, wm, wd);
    check("rmw_b_lat", cyc, 3);
    check("rmw_b_wdata", wd, 32'hAA223344);
    check("rmw_b_wmask", {28'd0, wm}, 32'hF);
    check("rmw_b_rdata", rd, 32'd0);
    do_req(1, 1'b0, 2'b00, 32'h23, 32'h0, cyc, rd, er, ce, wm, wd);
    check("bld_23", rd, 32'h000000AA);
    do_req(0, 1'b0, 2'b01, 32'h20, 32'h0, cyc, rd, er, ce, wm, wd);
    check("hld_20", rd, 32'h00003344);
    do_req(0, 1'b1, 2'b01, 32'h22, 32'h0000BEEF, cyc, rd, er, ce, wm, wd);
    check("rmw_h_lat", cyc, 3);
    check("rmw_h_wdata", wd, 32'hBEEF3344);
    do_req(1, 1'b0, 2'b10, 32'h20, 32'h0, cyc, rd, er, ce, wm, wd);
    check("wld_20", rd, 32'hBEEF3344);
    do_req(0, 1'b1, 2'b00, 32'h24, 32'h12345677, cyc, rd, er, ce, wm, wd);
    check("bst0_lat", cyc, 2);
    check("bst0_wmask", {28'd0, wm}, 32'h1);
    do_req(0, 1'b0, 2'b00, 32'h24, 32'h0, cyc, rd, er, ce, wm, wd);
    check("bld_24", rd, 32'h00000077);

    // Rejected accesses.
    do_req(0, 1'b0, 2'b01, 32'h21, 32'h0, cyc, rd, er, ce, wm, wd);
    check("hmis_err", {31'd0, er}, 1);
    check("hmis_rdata", rd, 0);
    check("hmis_ce", {31'd0, ce}, 0);
    do_req(1, 1'b0, 2'b10, 32'h1000, 32'h0, cyc, rd, er, ce, wm, wd);
    check("oor_err", {31'd0, er}, 1);
    check("oor_ce", {31'd0, ce}, 0);
    do_req(0, 1'b0, 2'b10, 32'h12, 32'h0, cyc, rd, er, ce, wm, wd);
    check("wmis_err", {31'd0, er}, 1);

    // Reset during the WRITE cycle of a read-modify-write.
    do_req(0, 1'b1, 2'b10, 32'h40, 32'h11223344, cyc, rd, er, ce, wm, wd);
    m1_we = 1'b1; m1_size = 2'b00; m1_addr = 32'h41; m1_wdata = 32'h55; m1_req = 1'b1;
    @(negedge clk);
    check("abort_acc_rr", {31'd0, mem_rr}, 1);
    @(negedge clk);
    check("abort_wr_we", {31'd0, mem_we}, 1);
    check("abort_wr_data", mem_wdata, 32'h11225544);
    rst = 1'b1;
    #1;
    check("abort_out", {28'd0, mem_ce, mem_we, m1_ack, m0_ack}, 0);
    @(negedge clk);
    rst = 1'b0;
    m1_req = 1'b0;
    stray = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (m0_ack || m1_ack || mem_ce) stray = 1'b1;
    end
    check("abort_quiet", {31'd0, stray}, 0);
    check("abort_mem", mem[16], 32'h11223344);

    // m1 alone after reset, then both held continuously.
    do_req(1, 1'b0, 2'b10, 32'h40, 32'h0, cyc, rd, er, ce, wm, wd);
    check("post_rst_lat", cyc, 2);
    check("post_rst_data", rd, 32'h11223344);
    m0_we = 0; m0_size = 2'b10; m0_addr = 32'h10; m0_req = 1'b1;
    m1_we = 0; m1_size = 2'b10; m1_addr = 32'h20; m1_req = 1'b1;
    nack = 0;
    for (int n = 1; n <= 16 && nack < 4; n++) begin
      @(negedge clk);
      if (m0_ack || m1_ack) begin
        ack_id[nack] = m1_ack ? 1 : 0;
        ack_at[nack] = n;
        ack_rd[nack] = m1_ack ? m1_rdata : m0_rdata;
        nack++;
      end
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    check("rr_count", nack, 4);
    for (int k = 0; k < nack; k++) begin
      check($sformatf("rr_id%0d", k), ack_id[k], k % 2);
      check($sformatf("rr_at%0d", k), ack_at[k], 2 + 3 * k);
      check($sformatf("rr_rd%0d", k), ack_rd[k], (k % 2 == 0) ? 32'hDEADBEEF : 32'hBEEF3344);
    end
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
